// File: rtl/bit_serializer_if.sv
// Parallel-load / serial-out bus of the bit serializer.
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both 1; load_data and load_len must be stable while
// load_valid is 1, and load_ready never depends on a transfer already made.
// ser_out/ser_valid/frame_done are a stream with no back-pressure.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  localparam int LW = $clog2(WIDTH) + 1;

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LW-1:0]    load_len;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;

  // Upstream producer and downstream consumer side
  modport master (
    output load_valid,
    output load_data,
    output load_len,
    output abort,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_done
  );

  // Serializer side
  modport slave (
    input  load_valid,
    input  load_data,
    input  load_len,
    input  abort,
    output load_ready,
    output ser_out,
    output ser_valid,
    output frame_done
  );
endinterface

// File: rtl/bit_serializer.sv
// Bit serializer: captures a parallel word with a length and presents it one
// bit per cycle, MSB or LSB first. Back-to-back frames are gap-free when the
// next word is offered during the last bit of the current one.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    RESET,
  bit_serializer_if.slave         bus,
  output logic                    busy_dbg_o   // 1 while the FSM is in SHIFT
);

  localparam int LW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;      // bits still to be sent, next one at the exit end
  logic [LW-1:0]    cnt_q;        // bits of the frame left, counting the one on ser_out
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             frame_done_q;

  logic             last_bit;
  logic             load_ready;
  logic             accept;
  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] aligned;
  logic             first_bit;
  logic [WIDTH-1:0] rest_bits;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Handshake, effective length and the bit-selection paths for both orders
  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt_q == LW'(1));
    load_ready = !RESET && !bus.abort && ((state_q == IDLE) || last_bit);
    accept     = bus.load_valid && load_ready;

    if ((bus.load_len == '0) || (bus.load_len > LW'(WIDTH))) begin
      eff_len = LW'(WIDTH);
    end else begin
      eff_len = bus.load_len;
    end

    // Move bit len-1 up to the MSB so MSB-first always exits from the top
    aligned = bus.load_data << (LW'(WIDTH) - eff_len);

    if (MSB_FIRST) begin
      first_bit     = aligned[WIDTH-1];
      rest_bits     = aligned << 1;
      next_bit      = shreg_q[WIDTH-1];
      shreg_shifted = shreg_q << 1;
    end else begin
      first_bit     = bus.load_data[0];
      rest_bits     = bus.load_data >> 1;
      next_bit      = shreg_q[0];
      shreg_shifted = shreg_q >> 1;
    end
  end

  // Two-state FSM with registered serial outputs
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= SHIFT;
            ser_out_q    <= first_bit;
            shreg_q      <= rest_bits;
            cnt_q        <= eff_len;
            ser_valid_q  <= 1'b1;
            frame_done_q <= (eff_len == LW'(1));
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            // Drop the frame; ser_out keeps its last value
            state_q      <= IDLE;
            cnt_q        <= '0;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
          end else if (last_bit) begin
            if (accept) begin
              // Chain the next word with no idle cycle
              state_q      <= SHIFT;
              ser_out_q    <= first_bit;
              shreg_q      <= rest_bits;
              cnt_q        <= eff_len;
              ser_valid_q  <= 1'b1;
              frame_done_q <= (eff_len == LW'(1));
            end else begin
              state_q      <= IDLE;
              cnt_q        <= '0;
              ser_valid_q  <= 1'b0;
              frame_done_q <= 1'b0;
            end
          end else begin
            // cnt_q >= 2 here, so the decrement cannot wrap
            ser_out_q    <= next_bit;
            shreg_q      <= shreg_shifted;
            cnt_q        <= cnt_q - LW'(1);
            ser_valid_q  <= 1'b1;
            frame_done_q <= (cnt_q == LW'(2));
          end
        end
        default: begin
          state_q     <= IDLE;
          ser_valid_q <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign busy_dbg_o     = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_bit_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv;
  logic [7:0] ld;
  logic [3:0] ll;
  logic       ab;
  logic       busy_m;
  logic       busy_l;

  bit_serializer_if #(.WIDTH(8)) m_if ();
  bit_serializer_if #(.WIDTH(8)) l_if ();

  assign m_if.load_valid = lv;
  assign m_if.load_data  = ld;
  assign m_if.load_len   = ll;
  assign m_if.abort      = ab;
  assign l_if.load_valid = lv;
  assign l_if.load_data  = ld;
  assign l_if.load_len   = ll;
  assign l_if.abort      = ab;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .RESET      (rst),
    .bus        (m_if.slave),
    .busy_dbg_o (busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .RESET      (rst),
    .bus        (l_if.slave),
    .busy_dbg_o (busy_l)
  );

  // ---------------- scoreboard / model ----------------
  int tests  = 0;
  int failed = 0;

  logic [0:0] exp_m_q[$];   // remaining bits of the MSB-first frame, front on ser_out
  logic [0:0] exp_l_q[$];   // same for the LSB-first frame
  logic       out_m;
  logic       out_l;
  logic       accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int eff_len(input logic [3:0] l);
    return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
  endfunction

  // One clock: check the combinational ready, advance the model, check outputs
  task automatic cycle();
    logic ready_exp;
    logic acc;
    int   n;
    #1;
    ready_exp = !rst && !ab && (exp_m_q.size() <= 1);
    chk("ready_msb", m_if.load_ready, ready_exp);
    chk("ready_lsb", l_if.load_ready, ready_exp);
    acc      = lv && ready_exp;
    accepted = acc;
    n        = eff_len(ll);
    @(posedge clk);
    if (rst) begin
      exp_m_q.delete();
      exp_l_q.delete();
      out_m = 1'b0;
      out_l = 1'b0;
    end else if (ab && (exp_m_q.size() > 0)) begin
      exp_m_q.delete();
      exp_l_q.delete();
    end else if (acc) begin
      exp_m_q.delete();
      exp_l_q.delete();
      for (int i = n - 1; i >= 0; i--) exp_m_q.push_back(ld[i]);
      for (int i = 0; i < n; i++) exp_l_q.push_back(ld[i]);
    end else if (exp_m_q.size() > 0) begin
      void'(exp_m_q.pop_front());
      void'(exp_l_q.pop_front());
    end
    if (exp_m_q.size() > 0) begin
      out_m = exp_m_q[0];
      out_l = exp_l_q[0];
    end
    #1;
    chk("valid_msb", m_if.ser_valid,  exp_m_q.size() > 0);
    chk("valid_lsb", l_if.ser_valid,  exp_l_q.size() > 0);
    chk("out_msb",   m_if.ser_out,    out_m);
    chk("out_lsb",   l_if.ser_out,    out_l);
    chk("done_msb",  m_if.frame_done, exp_m_q.size() == 1);
    chk("done_lsb",  l_if.frame_done, exp_l_q.size() == 1);
    chk("busy_msb",  busy_m,          exp_m_q.size() > 0);
    chk("busy_lsb",  busy_l,          exp_l_q.size() > 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    lv = 1'b0;
    repeat (n) cycle();
  endtask

  // Offer a word until it is taken; load_valid is left high for chaining
  task automatic send(input logic [7:0] d, input logic [3:0] l);
    lv = 1'b1;
    ld = d;
    ll = l;
    accepted = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (accepted) break;
    end
    chk("send_accept", accepted, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; lv = 1'b0; ld = '0; ll = '0; ab = 1'b0;
    out_m = 1'b0; out_l = 1'b0; accepted = 1'b0;

    cycle();
    cycle();
    rst = 1'b0;
    idle(1);                      // ready right after reset release

    send(8'hF0, 4'd8);            // 1111_0000 MSB-first, 0000_1111 LSB-first
    idle(10);

    send(8'hFF, 4'd8);            // held valid: FF then 00 back to back
    send(8'h00, 4'd8);
    idle(10);

    send(8'b0000_0101, 4'd3);     // short frame
    idle(5);
    send(8'hAA, 4'd0);            // len 0 means full width
    idle(10);
    send(8'h96, 4'd9);            // len above width means full width
    idle(10);
    send(8'h01, 4'd1);            // single-bit frame
    send(8'h00, 4'd1);
    idle(3);

    send(8'hFF, 4'd8);            // abort during bit 4
    lv = 1'b0;
    idle(3);
    ab = 1'b1;
    idle(1);
    ab = 1'b0;
    idle(2);

    ab = 1'b1;                    // abort while idle blocks acceptance only
    lv = 1'b1; ld = 8'h55; ll = 4'd8;
    cycle();
    ab = 1'b0;
    idle(2);

    send(8'h0F, 4'd8);            // reset during bit 5
    lv = 1'b0;
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    send(8'h3C, 4'd8);
    idle(10);

    send(8'h01, 4'd8);            // LSB-first instance: 1,0,0,0,0,0,0,0
    idle(10);

    for (int c = 0; c < 600; c++) begin
      lv  = ($urandom_range(0, 3) != 0);
      ld  = 8'($urandom);
      ll  = 4'($urandom_range(0, 15));
      ab  = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 1'b0;
    ab  = 1'b0;
    idle(12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
